fgmt_thread_scheduler: RTL and testbench

Fetch-side thread scheduler for the fine-grained multithreaded core. Each cycle it picks the hardware thread to fetch, using round-robin over threads that are enabled and not stalled. It drives `TID_fetch` and `PCF` into `PC_updater`, and tracks each in-flight instruction's thread ID and valid bit through the Decode and Execute stages to produce `TID_EXE`. When a taken branch resolves in Execute, it squashes younger same-thread instructions and holds that thread out of the next fetch slot while its PC is redirected.

---
 rtl/fgmt_pkg.sv | 15 +
 rtl/rr_thread_arbiter.sv | 27 ++
 rtl/fgmt_thread_scheduler.sv | 80 ++++++++
 tb/tb_fgmt_thread_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fgmt_pkg.sv
// Shared sizes and types for the fine-grained multithreaded fetch scheduler.
package fgmt;

   localparam int unsigned THREAD_POOL_SIZE = 4;
   localparam int unsigned WIDTH            = 32;
   localparam int unsigned TID_W            = $clog2(THREAD_POOL_SIZE);

   typedef logic [TID_W-1:0] tid_t;

   typedef struct packed {
      tid_t tid;
      logic valid;
   } slot_t;

endpackage

// File: rtl/rr_thread_arbiter.sv
// Combinational rotate-priority pick: first eligible thread after last_tid, wrapping.
module rr_thread_arbiter
   import fgmt::*;
(
   input  logic [THREAD_POOL_SIZE-1:0] eligible,
   input  tid_t                        last_tid,
   output tid_t                        pick,
   output logic                        pick_valid
);

   tid_t idx;

   always_comb begin
      pick       = last_tid;
      pick_valid = 1'b0;
      idx        = last_tid;
      // The final iteration wraps back onto last_tid itself.
      for (int unsigned i = 1; i <= THREAD_POOL_SIZE; i++) begin
         idx = last_tid + tid_t'(i);
         if (!pick_valid && eligible[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fgmt_thread_scheduler.sv
// Fetch-side round-robin thread scheduler with F/D/E thread tracking and branch squash.
module fgmt_thread_scheduler
   import fgmt::*;
(
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [THREAD_POOL_SIZE-1:0]            thread_en,
   input  logic [THREAD_POOL_SIZE-1:0]            thread_stall,
   input  logic                                   fetch_stall,
   input  logic [THREAD_POOL_SIZE-1:0][WIDTH-1:0] PC_T,
   input  logic                                   EXE_BR_TAKEN,
   output tid_t                                   TID_fetch,
   output logic                                   fetch_valid,
   output logic [WIDTH-1:0]                       PCF,
   output tid_t                                   TID_DEC,
   output logic                                   valid_DEC,
   output tid_t                                   TID_EXE,
   output logic                                   valid_EXE,
   output logic                                   kill_F,
   output logic                                   kill_D
);

   slot_t f_q, d_q, e_q;
   tid_t  last_q;

   logic                        redir;
   logic [THREAD_POOL_SIZE-1:0] redir_block;
   logic [THREAD_POOL_SIZE-1:0] eligible;
   tid_t                        pick;
   logic                        pick_valid;

   assign redir = EXE_BR_TAKEN & e_q.valid & ~fetch_stall;

   // Keep the redirected thread out of this pick so it refetches with its new PC.
   always_comb begin
      redir_block = '0;
      if (redir) begin
         redir_block[e_q.tid] = 1'b1;
      end
   end

   assign eligible = thread_en & ~thread_stall & ~redir_block;

   rr_thread_arbiter u_arb (
      .eligible   (eligible),
      .last_tid   (last_q),
      .pick       (pick),
      .pick_valid (pick_valid)
   );

   assign kill_F = redir & f_q.valid & (f_q.tid == e_q.tid);
   assign kill_D = redir & d_q.valid & (d_q.tid == e_q.tid);

   always_ff @(posedge clk) begin
      if (reset) begin
         f_q    <= '0;
         d_q    <= '0;
         e_q    <= '0;
         last_q <= tid_t'(THREAD_POOL_SIZE - 1);
      end else if (!fetch_stall) begin
         d_q <= '{tid: f_q.tid, valid: f_q.valid & ~kill_F};
         e_q <= '{tid: d_q.tid, valid: d_q.valid & ~kill_D};
         if (pick_valid) begin
            f_q    <= '{tid: pick, valid: 1'b1};
            last_q <= pick;
         end else begin
            f_q.valid <= 1'b0;
         end
      end
   end

   assign TID_fetch   = f_q.tid;
   assign fetch_valid = f_q.valid;
   assign PCF         = PC_T[f_q.tid];
   assign TID_DEC     = d_q.tid;
   assign valid_DEC   = d_q.valid;
   assign TID_EXE     = e_q.tid;
   assign valid_EXE   = e_q.valid;

endmodule

// File: tb/tb_fgmt_thread_scheduler.sv
// Scoreboard bench: driver pushes model expectations per cycle, monitor pops and compares.
module tb_fgmt_thread_scheduler;

   localparam int N = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [N-1:0]        thread_en = '0;
   logic [N-1:0]        thread_stall = '0;
   logic                fetch_stall = 1'b0;
   logic [N-1:0][31:0]  PC_T = '0;
   logic                EXE_BR_TAKEN = 1'b0;
   logic [1:0]          TID_fetch, TID_DEC, TID_EXE;
   logic                fetch_valid, valid_DEC, valid_EXE, kill_F, kill_D;
   logic [31:0]         PCF;

   fgmt_thread_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .thread_en    (thread_en),
      .thread_stall (thread_stall),
      .fetch_stall  (fetch_stall),
      .PC_T         (PC_T),
      .EXE_BR_TAKEN (EXE_BR_TAKEN),
      .TID_fetch    (TID_fetch),
      .fetch_valid  (fetch_valid),
      .PCF          (PCF),
      .TID_DEC      (TID_DEC),
      .valid_DEC    (valid_DEC),
      .TID_EXE      (TID_EXE),
      .valid_EXE    (valid_EXE),
      .kill_F       (kill_F),
      .kill_D       (kill_D)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [1:0]  tf, td, te;
      logic        vf, vd, ve, kf, kd;
      logic [31:0] pcf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Model: slot 0 = Fetch, 1 = Decode, 2 = Execute; pointer is the last thread fetched.
   int   m_tid[3];
   bit   m_v[3];
   int   m_last;

   function automatic void model_reset();
      for (int s = 0; s < 3; s++) begin
         m_tid[s] = 0;
         m_v[s]   = 0;
      end
      m_last = N - 1;
   endfunction

   function automatic int rr_pick(logic [N-1:0] elig, int last);
      for (int k = 1; k <= N; k++) begin
         if (elig[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // Drives one cycle of inputs, records the expected outputs, then steps the model.
   task automatic cyc(input bit r, input logic [N-1:0] en, input logic [N-1:0] st,
                      input bit fs, input bit br);
      exp_t e;
      bit   redir, kf, kd;
      int   p;
      logic [N-1:0] elig;
      @(posedge clk);
      #2;
      reset        = r;
      thread_en    = en;
      thread_stall = st;
      fetch_stall  = fs;
      EXE_BR_TAKEN = br;
      for (int t = 0; t < N; t++) PC_T[t] = $urandom;
      cycle++;

      redir = br && m_v[2] && !fs;
      kf    = redir && m_v[0] && (m_tid[0] == m_tid[2]);
      kd    = redir && m_v[1] && (m_tid[1] == m_tid[2]);
      e.cyc = cycle;
      e.tf  = 2'(m_tid[0]);  e.vf = m_v[0];
      e.td  = 2'(m_tid[1]);  e.vd = m_v[1];
      e.te  = 2'(m_tid[2]);  e.ve = m_v[2];
      e.kf  = kf;            e.kd = kd;
      e.pcf = PC_T[m_tid[0]];
      exp_q.push_back(e);

      if (r) begin
         model_reset();
      end else if (!fs) begin
         elig = en & ~st;
         if (redir) elig[m_tid[2]] = 1'b0;
         p = rr_pick(elig, m_last);
         m_tid[2] = m_tid[1];  m_v[2] = m_v[1] && !kd;
         m_tid[1] = m_tid[0];  m_v[1] = m_v[0] && !kf;
         if (p >= 0) begin
            m_tid[0] = p;
            m_v[0]   = 1;
            m_last   = p;
         end else begin
            m_v[0] = 0;
         end
      end
   endtask

   task automatic chk(input string name, input int cyc_n, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("TID_fetch",   e.cyc, 32'(TID_fetch),   32'(e.tf));
         chk("fetch_valid", e.cyc, 32'(fetch_valid), 32'(e.vf));
         chk("TID_DEC",     e.cyc, 32'(TID_DEC),     32'(e.td));
         chk("valid_DEC",   e.cyc, 32'(valid_DEC),   32'(e.vd));
         chk("TID_EXE",     e.cyc, 32'(TID_EXE),     32'(e.te));
         chk("valid_EXE",   e.cyc, 32'(valid_EXE),   32'(e.ve));
         chk("kill_F",      e.cyc, 32'(kill_F),      32'(e.kf));
         chk("kill_D",      e.cyc, 32'(kill_D),      32'(e.kd));
         chk("PCF",         e.cyc, PCF,              e.pcf);
      end
   end

   always @(posedge clk) begin
      assert (!(fetch_stall && EXE_BR_TAKEN))
         else $error("EXE_BR_TAKEN asserted during fetch_stall");
   end

   initial begin
      bit          fs, br, done;
      logic [N-1:0] en, st;
      model_reset();

      repeat (2) cyc(1, 4'h0, 4'h0, 0, 0);
      // Round-robin over all threads
      repeat (6) cyc(0, 4'hF, 4'h0, 0, 0);
      // Sparse mask with a one-cycle stall on thread 2
      cyc(0, 4'b0101, 4'h0, 0, 0);
      cyc(0, 4'b0101, 4'b0100, 0, 0);
      repeat (4) cyc(0, 4'b0101, 4'h0, 0, 0);
      // No eligible thread, then thread 3 alone
      repeat (3) cyc(0, 4'h0, 4'h0, 0, 0);
      repeat (4) cyc(0, 4'b1000, 4'h0, 0, 0);
      // Branch squash on thread 1 with two threads interleaved
      done = 0;
      for (int i = 0; i < 10; i++) begin
         br = !done && m_v[2] && (m_tid[2] == 1);
         if (br) done = 1;
         cyc(0, 4'b0011, 4'h0, 0, br);
      end
      // Single-thread taken branch
      for (int i = 0; i < 6; i++) cyc(0, 4'b0100, 4'h0, 0, i == 3);
      // Global stall mid-sequence
      repeat (3) cyc(0, 4'hF, 4'h0, 0, 0);
      repeat (3) cyc(0, 4'hF, 4'h0, 1, 0);
      repeat (5) cyc(0, 4'hF, 4'h0, 0, 0);
      // Reset pulse with all slots valid
      cyc(1, 4'hF, 4'h0, 0, 1);
      repeat (4) cyc(0, 4'hF, 4'h0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         st = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         fs = ($urandom_range(0, 7) == 0);
         br = !fs && ($urandom_range(0, 2) == 0);
         cyc(($urandom_range(0, 99) == 0), en, st, fs, br);
      end

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
